// File: rtl/ram_req_arbiter_if.sv
// Bundle of the two client ports and the downstream single-port RAM port
// served by ram_req_arbiter. The arbiter takes the slave view.
interface ram_req_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_a_req;
  logic                  i_a_write;
  logic [ADDR_WIDTH-1:0] i_a_addr;
  logic [DATA_WIDTH-1:0] i_a_wdata;
  logic                  o_a_ack;
  logic                  o_a_rvalid;
  logic [DATA_WIDTH-1:0] o_a_rdata;
  logic                  o_a_err;

  logic                  i_b_req;
  logic                  i_b_write;
  logic [ADDR_WIDTH-1:0] i_b_addr;
  logic [DATA_WIDTH-1:0] i_b_wdata;
  logic                  o_b_ack;
  logic                  o_b_rvalid;
  logic [DATA_WIDTH-1:0] o_b_rdata;
  logic                  o_b_err;

  logic                  o_ram_request;
  logic                  o_ram_write;
  logic [ADDR_WIDTH-1:0] o_ram_address;
  logic [DATA_WIDTH-1:0] o_ram_data;
  logic [DATA_WIDTH-1:0] i_ram_data;
  logic                  i_ram_data_DV;

  modport slave (
    input  i_a_req, i_a_write, i_a_addr, i_a_wdata,
    output o_a_ack, o_a_rvalid, o_a_rdata, o_a_err,
    input  i_b_req, i_b_write, i_b_addr, i_b_wdata,
    output o_b_ack, o_b_rvalid, o_b_rdata, o_b_err,
    output o_ram_request, o_ram_write, o_ram_address, o_ram_data,
    input  i_ram_data, i_ram_data_DV
  );

  modport master (
    output i_a_req, i_a_write, i_a_addr, i_a_wdata,
    input  o_a_ack, o_a_rvalid, o_a_rdata, o_a_err,
    output i_b_req, i_b_write, i_b_addr, i_b_wdata,
    input  o_b_ack, o_b_rvalid, o_b_rdata, o_b_err,
    input  o_ram_request, o_ram_write, o_ram_address, o_ram_data,
    output i_ram_data, i_ram_data_DV
  );
endinterface

// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter giving two clients (A: fetch, B: load/store) one-at-a-time
// access to a single-port RAM, with a watchdog that aborts unanswered accesses.
module ram_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ram_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Abort fires on the WAIT cycle whose increment would make the count reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic                  err_a_q, err_a_d, err_b_q, err_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                  grant_b;
  logic [DATA_WIDTH-1:0] resp_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      ram_req_q  <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      ram_req_q  <= ram_req_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ram_req_d  = 1'b0;
    ram_wr_d   = ram_wr_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    err_a_d    = 1'b0;
    err_b_d    = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    grant_b    = 1'b0;
    // A write answers with its own data; a read answers with the RAM word.
    resp_data  = ram_wr_q ? ram_data_q : bus.i_ram_data;

    unique case (state_q)
      IDLE: begin
        if (bus.i_a_req || bus.i_b_req) begin
          grant_b    = bus.i_b_req && (!bus.i_a_req || ptr_q);
          owner_d    = grant_b;
          ptr_d      = !grant_b;
          ram_req_d  = 1'b1;
          ack_a_d    = !grant_b;
          ack_b_d    = grant_b;
          ram_wr_d   = grant_b ? bus.i_b_write : bus.i_a_write;
          ram_addr_d = grant_b ? bus.i_b_addr  : bus.i_a_addr;
          ram_data_d = grant_b ? bus.i_b_wdata : bus.i_a_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_ram_data_DV) begin
          if (owner_q) begin
            rvalid_b_d = 1'b1;
            rdata_b_d  = resp_data;
          end else begin
            rvalid_a_d = 1'b1;
            rdata_a_d  = resp_data;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          if (owner_q) begin
            rvalid_b_d = 1'b1;
            err_b_d    = 1'b1;
            rdata_b_d  = '0;
          end else begin
            rvalid_a_d = 1'b1;
            err_a_d    = 1'b1;
            rdata_a_d  = '0;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ram_request = ram_req_q;
  assign bus.o_ram_write   = ram_wr_q;
  assign bus.o_ram_address = ram_addr_q;
  assign bus.o_ram_data    = ram_data_q;
  assign bus.o_a_ack       = ack_a_q;
  assign bus.o_b_ack       = ack_b_q;
  assign bus.o_a_rvalid    = rvalid_a_q;
  assign bus.o_b_rvalid    = rvalid_b_q;
  assign bus.o_a_err       = err_a_q;
  assign bus.o_b_err       = err_b_q;
  assign bus.o_a_rdata     = rdata_a_q;
  assign bus.o_b_rdata     = rdata_b_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Directed bench for ram_req_arbiter: table of single transactions plus
// hand-written contention, timeout and mid-transaction reset sequences.
module tb_ram_req_arbiter;

  logic clk;
  logic rst_n;

  ram_req_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  ram_req_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .TIMEOUT(15)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: DV one cycle after the request.
  logic [7:0] mem [1024];
  logic       ram_dv;
  logic [7:0] ram_q;
  logic       suppress;
  logic       inject;

  initial begin
    ram_dv   <= 1'b0;
    ram_q    <= 8'h00;
    mem[1]   <= 8'h11;
    mem[2]   <= 8'h22;
    mem[5]   <= 8'h3C;
  end

  always @(posedge clk) begin
    ram_dv <= 1'b0;
    if (bus.o_ram_request && !suppress) begin
      ram_dv <= 1'b1;
      if (bus.o_ram_write) begin
        mem[bus.o_ram_address] <= bus.o_ram_data;
        ram_q <= bus.o_ram_data;
      end else begin
        ram_q <= mem[bus.o_ram_address];
      end
    end
  end

  assign bus.i_ram_data_DV = ram_dv | inject;
  assign bus.i_ram_data    = ram_q;

  int nvec;
  int nmis;
  logic [7:0] exp_rd_a;
  logic [7:0] exp_rd_b;

  typedef struct {
    bit         b;
    bit         w;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } txn_t;

  txn_t vec [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.o_a_ack, bus.o_b_ack, bus.o_a_rvalid, bus.o_b_rvalid,
             bus.o_a_rdata, bus.o_b_rdata, bus.o_a_err, bus.o_b_err,
             bus.o_ram_request, bus.o_ram_write, bus.o_ram_address, bus.o_ram_data};
  endfunction

  task automatic run_txn(input txn_t t);
    logic own_ack, oth_ack, own_rv, oth_rv, own_err;
    logic [7:0] own_rd, oth_rd, oth_exp;
    if (t.b) begin
      bus.i_b_req = 1'b1; bus.i_b_write = t.w; bus.i_b_addr = t.addr; bus.i_b_wdata = t.wdata;
    end else begin
      bus.i_a_req = 1'b1; bus.i_a_write = t.w; bus.i_a_addr = t.addr; bus.i_a_wdata = t.wdata;
    end
    tick();
    own_ack = t.b ? bus.o_b_ack : bus.o_a_ack;
    oth_ack = t.b ? bus.o_a_ack : bus.o_b_ack;
    chk("ack_owner", 32'(own_ack), 32'd1);
    chk("ack_other", 32'(oth_ack), 32'd0);
    chk("ram_request_on", 32'(bus.o_ram_request), 32'd1);
    chk("ram_address", 32'(bus.o_ram_address), 32'(t.addr));
    chk("ram_write", 32'(bus.o_ram_write), 32'(t.w));
    if (t.w) chk("ram_data", 32'(bus.o_ram_data), 32'(t.wdata));
    tick();
    own_ack = t.b ? bus.o_b_ack : bus.o_a_ack;
    own_rv  = t.b ? bus.o_b_rvalid : bus.o_a_rvalid;
    chk("ram_request_off", 32'(bus.o_ram_request), 32'd0);
    chk("ack_pulse", 32'(own_ack), 32'd0);
    chk("rvalid_early", 32'(own_rv), 32'd0);
    chk("ram_write_hold", 32'(bus.o_ram_write), 32'(t.w));
    if (t.b) bus.i_b_req = 1'b0; else bus.i_a_req = 1'b0;
    tick();
    own_rv  = t.b ? bus.o_b_rvalid : bus.o_a_rvalid;
    oth_rv  = t.b ? bus.o_a_rvalid : bus.o_b_rvalid;
    own_rd  = t.b ? bus.o_b_rdata  : bus.o_a_rdata;
    oth_rd  = t.b ? bus.o_a_rdata  : bus.o_b_rdata;
    own_err = t.b ? bus.o_b_err    : bus.o_a_err;
    oth_exp = t.b ? exp_rd_a : exp_rd_b;
    chk("rvalid_owner", 32'(own_rv), 32'd1);
    chk("rdata_owner", 32'(own_rd), 32'(t.exp));
    chk("err_owner", 32'(own_err), 32'd0);
    chk("rvalid_other", 32'(oth_rv), 32'd0);
    chk("rdata_other_hold", 32'(oth_rd), 32'(oth_exp));
    if (t.b) exp_rd_b = t.exp; else exp_rd_a = t.exp;
    tick();
    own_rv = t.b ? bus.o_b_rvalid : bus.o_a_rvalid;
    chk("rvalid_pulse", 32'(own_rv), 32'd0);
  endtask

  initial begin
    int last, grants, ga, gb, k;
    bit a_drop, b_drop;
    nvec = 0; nmis = 0;
    exp_rd_a = 8'h00; exp_rd_b = 8'h00;
    suppress = 1'b0; inject = 1'b0;
    rst_n = 1'b0;
    bus.i_a_req = 1'b0; bus.i_a_write = 1'b0; bus.i_a_addr = '0; bus.i_a_wdata = '0;
    bus.i_b_req = 1'b0; bus.i_b_write = 1'b0; bus.i_b_addr = '0; bus.i_b_wdata = '0;

    vec[0] = '{b:1'b0, w:1'b0, addr:10'h005, wdata:8'h00, exp:8'h3C};
    vec[1] = '{b:1'b1, w:1'b1, addr:10'h3FF, wdata:8'hA5, exp:8'hA5};
    vec[2] = '{b:1'b1, w:1'b0, addr:10'h3FF, wdata:8'h00, exp:8'hA5};
    vec[3] = '{b:1'b0, w:1'b1, addr:10'h010, wdata:8'h5A, exp:8'h5A};
    vec[4] = '{b:1'b0, w:1'b0, addr:10'h010, wdata:8'h00, exp:8'h5A};
    vec[5] = '{b:1'b1, w:1'b0, addr:10'h005, wdata:8'h00, exp:8'h3C};

    tick(); tick();
    chk("reset_outputs_zero", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs_zero", 32'(any_out()), 32'd0);

    foreach (vec[i]) run_txn(vec[i]);

    // Contention: both clients keep re-requesting; grants must alternate A,B,...
    bus.i_a_write = 1'b0; bus.i_a_addr = 10'h001;
    bus.i_b_write = 1'b0; bus.i_b_addr = 10'h002;
    bus.i_a_req = 1'b1; bus.i_b_req = 1'b1;
    last = -1; grants = 0; ga = 0; gb = 0; a_drop = 0; b_drop = 0;
    k = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (bus.o_ram_request) begin
        chk("cont_ack", 32'({bus.o_a_ack, bus.o_b_ack}), (k == 0) ? 32'd2 : 32'd1);
        chk("cont_addr", 32'(bus.o_ram_address), (k == 0) ? 32'h001 : 32'h002);
        if (last >= 0) chk("cont_spacing", 32'(cyc - last), 32'd3);
        if (k == 0) ga++; else gb++;
        k = 1 - k;
        last = cyc; grants++;
      end
      if (a_drop) begin bus.i_a_req = 1'b0; a_drop = 0; end
      if (b_drop) begin bus.i_b_req = 1'b0; b_drop = 0; end
      if (bus.o_a_ack) a_drop = 1;
      if (bus.o_b_ack) b_drop = 1;
      if (bus.o_a_rvalid) begin
        chk("cont_rdata_a", 32'(bus.o_a_rdata), 32'h11);
        bus.i_a_req = 1'b1;
      end
      if (bus.o_b_rvalid) begin
        chk("cont_rdata_b", 32'(bus.o_b_rdata), 32'h22);
        bus.i_b_req = 1'b1;
      end
    end
    bus.i_a_req = 1'b0; bus.i_b_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("cont_grants", 32'(grants), 32'd7);
    chk("cont_grants_a", 32'(ga), 32'd4);
    chk("cont_grants_b", 32'(gb), 32'd3);
    exp_rd_a = 8'h11; exp_rd_b = 8'h22;

    // Timeout: RAM swallows one access.
    suppress = 1'b1;
    bus.i_a_write = 1'b0; bus.i_a_addr = 10'h005; bus.i_a_req = 1'b1;
    tick();
    chk("tmo_ack", 32'(bus.o_a_ack), 32'd1);
    tick();
    suppress = 1'b0; bus.i_a_req = 1'b0;
    k = 2;
    while (!bus.o_a_rvalid && k < 40) begin
      tick();
      k++;
    end
    chk("tmo_latency", 32'(k), 32'd17);
    chk("tmo_err", 32'(bus.o_a_err), 32'd1);
    chk("tmo_rdata", 32'(bus.o_a_rdata), 32'd0);
    chk("tmo_b_rvalid", 32'(bus.o_b_rvalid), 32'd0);
    chk("tmo_b_rdata", 32'(bus.o_b_rdata), 32'(exp_rd_b));
    exp_rd_a = 8'h00;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("stale_dv_a", 32'(bus.o_a_rvalid), 32'd0);
    chk("stale_dv_b", 32'(bus.o_b_rvalid), 32'd0);
    chk("stale_dv_err", 32'(bus.o_a_err), 32'd0);
    chk("stale_dv_req", 32'(bus.o_ram_request), 32'd0);
    run_txn(vec[0]);

    // Reset during WAIT of an A read; B is favoured by the pointer beforehand.
    suppress = 1'b1;
    bus.i_a_write = 1'b0; bus.i_a_addr = 10'h002; bus.i_a_req = 1'b1;
    tick();
    chk("rst_pre_ack", 32'(bus.o_a_ack), 32'd1);
    tick();
    bus.i_a_req = 1'b0; suppress = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_zero", 32'(any_out()), 32'd0);
    rst_n = 1'b1;
    exp_rd_a = 8'h00; exp_rd_b = 8'h00;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("rst_late_dv_a", 32'(bus.o_a_rvalid), 32'd0);
    chk("rst_late_dv_b", 32'(bus.o_b_rvalid), 32'd0);
    bus.i_a_addr = 10'h001; bus.i_b_addr = 10'h002;
    bus.i_a_req = 1'b1; bus.i_b_req = 1'b1;
    tick();
    chk("rst_ptr_grant", 32'({bus.o_a_ack, bus.o_b_ack}), 32'd2);
    chk("rst_ptr_addr", 32'(bus.o_ram_address), 32'h001);
    tick();
    bus.i_a_req = 1'b0;
    tick();
    chk("rst_a_rvalid", 32'(bus.o_a_rvalid), 32'd1);
    chk("rst_a_rdata", 32'(bus.o_a_rdata), 32'h11);
    tick();
    chk("rst_b_ack", 32'(bus.o_b_ack), 32'd1);
    chk("rst_b_addr", 32'(bus.o_ram_address), 32'h002);
    tick();
    bus.i_b_req = 1'b0;
    tick();
    chk("rst_b_rvalid", 32'(bus.o_b_rvalid), 32'd1);
    chk("rst_b_rdata", 32'(bus.o_b_rdata), 32'h22);
    chk("rst_b_err", 32'(bus.o_b_err), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
